trigger_capture_ctrl: RTL

TRIGGER_CAPTURE_CTRL -- requirements
Module: trigger_capture_ctrl

---
 rtl/trigger_capture_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/trigger_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | trigger_capture_ctrl: pretrigger capture controller (auto/normal/    |
// | single). Define TRIG_HYST_EN to enable trigger hysteresis.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trigger_capture_ctrl #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int PRE          = 160,
  parameter int AUTO_TIMEOUT = 2048,
  parameter int HYST         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        trig_mode,
  input  logic              arm,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              capture_done,
  output logic              triggered,
  output logic [2:0]        state_out
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_PREFILL = 3'd1;
  localparam logic [2:0] c_ARMED   = 3'd2;
  localparam logic [2:0] c_POST    = 3'd3;
  localparam logic [2:0] c_HOLD    = 3'd4;

  localparam int              c_AUTO_W    = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [c_AUTO_W-1:0] c_AUTO_LAST = c_AUTO_W'(AUTO_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_PRE_LAST  = ADDR_W'((PRE > 0) ? PRE - 1 : 0);
  localparam logic [ADDR_W-1:0] c_POST_N    = ADDR_W'(DEPTH - PRE - 1);
  localparam logic [ADDR_W-1:0] c_PRE_A     = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] c_WRAP_OFF  = ADDR_W'(DEPTH - PRE);

  logic [2:0]          r_state, w_next;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_ptr, r_cnt, w_ptr_next, w_start;
  logic [c_AUTO_W-1:0] r_auto;
  logic [DATA_W-1:0]   r_prev;
  logic                r_prev_valid;
  logic                w_rise, w_fall, w_real, w_timeout, w_fire, w_armed_smp;
  logic                w_write, w_enter_pre, w_enter_armed, w_done, w_sample_mode;

  // Pointer math stays modulo DEPTH, which need not be a power of two.
  assign w_ptr_next = (r_ptr == c_LAST_ADDR) ? '0 : r_ptr + 1'b1;
  assign w_start    = (r_ptr >= c_PRE_A) ? r_ptr - c_PRE_A : r_ptr + c_WRAP_OFF;
  assign w_armed_smp = (r_state == c_ARMED) && sample_valid;
  assign state_out  = r_state;

`ifdef TRIG_HYST_EN
  localparam logic [DATA_W:0] c_HYST = (DATA_W + 1)'(HYST);

  logic              r_seen_lo, r_seen_hi;
  logic [DATA_W:0]   w_lo_diff, w_hi_sum;
  logic [DATA_W-1:0] w_lo, w_hi;

  assign w_lo_diff = {1'b0, trig_level} - c_HYST;
  assign w_hi_sum  = {1'b0, trig_level} + c_HYST;
  assign w_lo      = w_lo_diff[DATA_W] ? '0 : w_lo_diff[DATA_W-1:0];
  assign w_hi      = w_hi_sum[DATA_W]  ? '1 : w_hi_sum[DATA_W-1:0];

  // Re-arm flags: the signal must leave the band before another edge counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seen_lo <= 1'b0;
      r_seen_hi <= 1'b0;
    end else if (w_enter_armed || w_fire) begin
      r_seen_lo <= 1'b0;
      r_seen_hi <= 1'b0;
    end else if (w_armed_smp) begin
      if (sample_data < w_lo) r_seen_lo <= 1'b1;
      if (sample_data > w_hi) r_seen_hi <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_rise = r_prev_valid && (r_prev < trig_level) && (sample_data >= trig_level);
    w_fall = r_prev_valid && (r_prev > trig_level) && (sample_data <= trig_level);
`ifdef TRIG_HYST_EN
    w_rise = w_rise && r_seen_lo;
    w_fall = w_fall && r_seen_hi;
`endif
    w_real    = w_armed_smp && (trig_slope ? w_fall : w_rise);
    w_timeout = w_armed_smp && (r_mode == 2'b00) && (r_auto == c_AUTO_LAST);
    w_fire    = w_real || w_timeout;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if ((trig_mode != 2'b10) || arm) w_next = c_PREFILL;
      c_PREFILL: begin
        if (PRE == 0) w_next = c_ARMED;
        else if (sample_valid && (r_cnt == c_PRE_LAST)) w_next = c_ARMED;
      end
      c_ARMED:   if (w_fire) w_next = (DEPTH - PRE - 1 == 0) ? c_HOLD : c_POST;
      c_POST:    if (sample_valid && (r_cnt == ADDR_W'(1))) w_next = c_HOLD;
      c_HOLD:    if (frame_done) w_next = (trig_mode == 2'b10) ? c_IDLE : c_PREFILL;
      default:   w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_write       = sample_valid &&
                    ((r_state == c_PREFILL) || (r_state == c_ARMED) || (r_state == c_POST));
    w_enter_pre   = (w_next == c_PREFILL) && (r_state != c_PREFILL);
    w_enter_armed = (w_next == c_ARMED)   && (r_state != c_ARMED);
    w_done        = (w_next == c_HOLD)    && (r_state != c_HOLD);
    w_sample_mode = (r_state == c_IDLE)   || (r_state == c_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      start_addr   <= '0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
      r_mode       <= 2'b00;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_auto       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      wr_en        <= w_write;
      capture_done <= w_done;
      if (w_sample_mode) r_mode <= trig_mode;
      if (w_write) begin
        wr_data      <= sample_data;
        wr_addr      <= r_ptr;
        r_ptr        <= w_ptr_next;
        r_prev       <= sample_data;
        r_prev_valid <= 1'b1;
      end
      case (r_state)
        c_PREFILL: if (w_write) r_cnt <= r_cnt + 1'b1;
        c_ARMED: begin
          if (w_fire) begin
            start_addr <= w_start;
            triggered  <= w_real;
            r_cnt      <= c_POST_N;
          end else if (sample_valid) begin
            r_auto <= r_auto + 1'b1;
          end
        end
        c_POST:    if (w_write) r_cnt <= r_cnt - 1'b1;
        default:   ;
      endcase
      if (w_enter_pre) begin
        r_ptr        <= '0;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
      end
      if (w_enter_armed) r_auto <= '0;
    end
  end

endmodule
`default_nettype wire
